// File: rtl/icache_fetch_arb_pkg.sv
// rtl/icache_fetch_arb_pkg.sv - shared types, sizes and helpers for the icache fetch arbiter
package icache_fetch_arb_pkg;

    localparam int ICACHE_TAG_WIDTH   = 2;
    localparam int ICACHE_ARB_ENTRIES = 4;
    localparam int ICACHE_CNT_WIDTH   = 3;

    typedef enum logic {
        OWNER_DEMAND   = 1'b0,
        OWNER_PREFETCH = 1'b1
    } owner_e;

    typedef struct packed {
        logic                        valid;
        owner_e                      owner;
        logic                        killed;
        logic [ICACHE_TAG_WIDTH-1:0] id;
    } sb_entry_t;

    // Lowest-index entry whose valid bit is clear; callers only use the
    // result when at least one entry is free.
    function automatic logic [ICACHE_TAG_WIDTH-1:0] lowest_free_idx(
        input logic [ICACHE_ARB_ENTRIES-1:0] valid_vec
    );
        logic [ICACHE_TAG_WIDTH-1:0] idx;
        logic                        found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < ICACHE_ARB_ENTRIES; i++) begin
            if (!valid_vec[i] && !found) begin
                idx   = ICACHE_TAG_WIDTH'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/icache_fetch_arb_sb.sv
// rtl/icache_fetch_arb_sb.sv - 4-entry lookup tag scoreboard (alloc, free, kill, lookup, free count)
module icache_fetch_arb_sb
    import icache_fetch_arb_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        alloc_en,
    input  owner_e                      alloc_owner,
    input  logic [ICACHE_TAG_WIDTH-1:0] alloc_id,
    output logic [ICACHE_TAG_WIDTH-1:0] alloc_tag,
    input  logic                        rsp_en,
    input  logic [ICACHE_TAG_WIDTH-1:0] rsp_tag,
    output logic                        rsp_hit,
    output owner_e                      rsp_owner,
    output logic                        rsp_killed,
    output logic [ICACHE_TAG_WIDTH-1:0] rsp_id,
    input  logic                        kill_en,
    output logic [ICACHE_CNT_WIDTH-1:0] free_cnt
);

    sb_entry_t                     entries [ICACHE_ARB_ENTRIES];
    logic [ICACHE_ARB_ENTRIES-1:0] valid_vec;

    // Gather valid bits for the allocation priority pick.
    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < ICACHE_ARB_ENTRIES; i++) begin
            valid_vec[i] = entries[i].valid;
        end
    end

    assign alloc_tag = lowest_free_idx(valid_vec);

    // Responses to entries that are not valid are ignored entirely.
    assign rsp_hit    = rsp_en & entries[rsp_tag].valid;
    assign rsp_owner  = entries[rsp_tag].owner;
    assign rsp_killed = entries[rsp_tag].killed;
    assign rsp_id     = entries[rsp_tag].id;

    // Entry state: kill marks demand entries, a response frees, a grant allocates.
    // The allocated slot is always one that was free at the start of the
    // cycle, so it can never collide with the slot being freed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ICACHE_ARB_ENTRIES; i++) begin
                entries[i] <= '0;
            end
            free_cnt <= ICACHE_CNT_WIDTH'(ICACHE_ARB_ENTRIES);
        end else begin
            for (int i = 0; i < ICACHE_ARB_ENTRIES; i++) begin
                if (kill_en && entries[i].valid && entries[i].owner == OWNER_DEMAND) begin
                    entries[i].killed <= 1'b1;
                end
                if (rsp_hit && rsp_tag == ICACHE_TAG_WIDTH'(i)) begin
                    entries[i].valid <= 1'b0;
                end
                if (alloc_en && alloc_tag == ICACHE_TAG_WIDTH'(i)) begin
                    entries[i] <= '{valid: 1'b1, owner: alloc_owner, killed: 1'b0, id: alloc_id};
                end
            end
            free_cnt <= free_cnt + {{(ICACHE_CNT_WIDTH-1){1'b0}}, rsp_hit}
                                 - {{(ICACHE_CNT_WIDTH-1){1'b0}}, alloc_en};
        end
    end

    // A response must always name an outstanding lookup.
    rsp_to_valid_entry: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_en |-> valid_vec[rsp_tag]);

endmodule

// File: rtl/icache_fetch_arb.sv
// rtl/icache_fetch_arb.sv - IFU/prefetch arbiter for the icache lookup port (optional ICACHE_FETCH_ARB_PERF_EN)
module icache_fetch_arb
    import icache_fetch_arb_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int PF_AGE_MAX = 7,
    parameter int PF_RESERVE = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_flush,
    input  logic                        i_ifu_vld,
    input  logic [PC_WIDTH-1:0]         i_ifu_pc,
    input  logic [ICACHE_TAG_WIDTH-1:0] i_ifu_id,
    output logic                        o_ifu_rdy,
    input  logic                        i_pf_vld,
    input  logic [PC_WIDTH-1:0]         i_pf_pc,
    output logic                        o_pf_rdy,
    output logic                        o_icache_vld,
    output logic [PC_WIDTH-1:0]         o_icache_pc,
    output logic [ICACHE_TAG_WIDTH-1:0] o_icache_tag,
    input  logic                        i_icache_stall,
    input  logic                        i_icache_rsp_vld,
    input  logic [ICACHE_TAG_WIDTH-1:0] i_icache_rsp_tag,
    output logic                        o_ifu_rsp_vld,
    output logic [ICACHE_TAG_WIDTH-1:0] o_ifu_rsp_id,
`ifdef ICACHE_FETCH_ARB_PERF_EN
    output logic [31:0]                 o_perf_demand_issue,
    output logic [31:0]                 o_perf_pf_issue,
    output logic [31:0]                 o_perf_killed_drop,
    output logic [31:0]                 o_perf_full_cycles,
`endif
    output logic                        o_pf_rsp_vld
);

    logic [2:0]                  age;
    logic [ICACHE_CNT_WIDTH-1:0] free_cnt;
    logic [ICACHE_TAG_WIDTH-1:0] alloc_tag;
    logic                        rsp_hit;
    owner_e                      rsp_owner;
    logic                        rsp_killed;
    logic [ICACHE_TAG_WIDTH-1:0] rsp_id;
    logic                        suppress;
    logic                        pf_room;
    logic                        age_ovr;
    logic                        dem_gnt;
    logic                        pf_gnt;

    // Grant: demand first, prefetch only with reserve headroom, an aged
    // prefetch overrides demand for one cycle.
    always_comb begin
        suppress = !rst_n || i_icache_stall || i_flush || (free_cnt == '0);
        pf_room  = free_cnt > ICACHE_CNT_WIDTH'(PF_RESERVE);
        age_ovr  = (age == 3'(PF_AGE_MAX)) && i_pf_vld && pf_room;
        dem_gnt  = !suppress && i_ifu_vld && !age_ovr;
        pf_gnt   = !suppress && ((i_pf_vld && !i_ifu_vld && pf_room) || age_ovr);
    end

    assign o_ifu_rdy    = dem_gnt;
    assign o_pf_rdy     = pf_gnt;
    assign o_icache_vld = dem_gnt | pf_gnt;
    assign o_icache_pc  = pf_gnt ? i_pf_pc : i_ifu_pc;
    assign o_icache_tag = alloc_tag;

    // Response routing: killed demand lookups and demand responses that
    // land in a flush cycle are dropped.
    assign o_ifu_rsp_vld = rsp_hit && rsp_owner == OWNER_DEMAND && !rsp_killed && !i_flush;
    assign o_ifu_rsp_id  = rsp_id;
    assign o_pf_rsp_vld  = rsp_hit && rsp_owner == OWNER_PREFETCH;

    icache_fetch_arb_sb u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_en    (dem_gnt | pf_gnt),
        .alloc_owner (pf_gnt ? OWNER_PREFETCH : OWNER_DEMAND),
        .alloc_id    (i_ifu_id),
        .alloc_tag   (alloc_tag),
        .rsp_en      (i_icache_rsp_vld & rst_n),
        .rsp_tag     (i_icache_rsp_tag),
        .rsp_hit     (rsp_hit),
        .rsp_owner   (rsp_owner),
        .rsp_killed  (rsp_killed),
        .rsp_id      (rsp_id),
        .kill_en     (i_flush),
        .free_cnt    (free_cnt)
    );

    // Prefetch age: counts cycles a waiting prefetch is passed over, frozen under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else if (!i_icache_stall) begin
            if (!i_pf_vld || pf_gnt) begin
                age <= '0;
            end else if (age != 3'(PF_AGE_MAX)) begin
                age <= age + 3'd1;
            end
        end
    end

`ifdef ICACHE_FETCH_ARB_PERF_EN
    // Wrapping event counters for issue, drop and full-stall activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_perf_demand_issue <= '0;
            o_perf_pf_issue     <= '0;
            o_perf_killed_drop  <= '0;
            o_perf_full_cycles  <= '0;
        end else begin
            if (dem_gnt) o_perf_demand_issue <= o_perf_demand_issue + 32'd1;
            if (pf_gnt)  o_perf_pf_issue     <= o_perf_pf_issue + 32'd1;
            if (rsp_hit && rsp_owner == OWNER_DEMAND && (rsp_killed || i_flush)) begin
                o_perf_killed_drop <= o_perf_killed_drop + 32'd1;
            end
            if (free_cnt == '0 && (i_ifu_vld || i_pf_vld)) begin
                o_perf_full_cycles <= o_perf_full_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_fetch_arb.sv
// tb/tb_icache_fetch_arb.sv - randomized self-checking bench with a behavioural arbiter model
module tb_icache_fetch_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_ifu_vld = 1'b0;
    logic [31:0] i_ifu_pc = '0;
    logic [1:0]  i_ifu_id = '0;
    logic        o_ifu_rdy;
    logic        i_pf_vld = 1'b0;
    logic [31:0] i_pf_pc = '0;
    logic        o_pf_rdy;
    logic        o_icache_vld;
    logic [31:0] o_icache_pc;
    logic [1:0]  o_icache_tag;
    logic        i_icache_stall = 1'b0;
    logic        i_icache_rsp_vld = 1'b0;
    logic [1:0]  i_icache_rsp_tag = '0;
    logic        o_ifu_rsp_vld;
    logic [1:0]  o_ifu_rsp_id;
    logic        o_pf_rsp_vld;
`ifdef ICACHE_FETCH_ARB_PERF_EN
    logic [31:0] o_perf_demand_issue, o_perf_pf_issue, o_perf_killed_drop, o_perf_full_cycles;
`endif

    always #5 clk = ~clk;

    icache_fetch_arb dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_flush          (i_flush),
        .i_ifu_vld        (i_ifu_vld),
        .i_ifu_pc         (i_ifu_pc),
        .i_ifu_id         (i_ifu_id),
        .o_ifu_rdy        (o_ifu_rdy),
        .i_pf_vld         (i_pf_vld),
        .i_pf_pc          (i_pf_pc),
        .o_pf_rdy         (o_pf_rdy),
        .o_icache_vld     (o_icache_vld),
        .o_icache_pc      (o_icache_pc),
        .o_icache_tag     (o_icache_tag),
        .i_icache_stall   (i_icache_stall),
        .i_icache_rsp_vld (i_icache_rsp_vld),
        .i_icache_rsp_tag (i_icache_rsp_tag),
        .o_ifu_rsp_vld    (o_ifu_rsp_vld),
        .o_ifu_rsp_id     (o_ifu_rsp_id),
`ifdef ICACHE_FETCH_ARB_PERF_EN
        .o_perf_demand_issue (o_perf_demand_issue),
        .o_perf_pf_issue     (o_perf_pf_issue),
        .o_perf_killed_drop  (o_perf_killed_drop),
        .o_perf_full_cycles  (o_perf_full_cycles),
`endif
        .o_pf_rsp_vld     (o_pf_rsp_vld)
    );

    int n_total = 0;
    int n_bad   = 0;

    // reference model: per-tag bookkeeping, the prefetch wait count and event totals
    bit       m_busy [4];
    bit       m_pf   [4];
    bit       m_dead [4];
    bit [1:0] m_id   [4];
    int       m_wait = 0;
    int       m_dem_cnt = 0, m_pf_cnt = 0, m_drop_cnt = 0, m_full_cnt = 0;

    // values seen at the last step, for directed checks
    logic       s_ifu_rdy, s_pf_rdy, s_icache_vld, s_ifu_rsp_vld, s_pf_rsp_vld;
    logic [1:0] s_tag, s_rsp_id;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int free_slots();
        int n = 0;
        for (int i = 0; i < 4; i++) if (!m_busy[i]) n++;
        return n;
    endfunction

    function automatic int oldest_busy();
        for (int i = 0; i < 4; i++) if (m_busy[i]) return i;
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_busy[i] = 0; m_pf[i] = 0; m_dead[i] = 0; m_id[i] = '0;
        end
        m_wait = 0;
    endtask

    task automatic step(input bit ifu, input logic [31:0] pc, input logic [1:0] id,
                        input bit pf, input logic [31:0] ppc, input bit st, input bit fl,
                        input bit rv, input logic [1:0] rt);
        int  nfree, first;
        bit  blocked, overtake, eg_dem, eg_pf, e_irsp, e_prsp;
        @(negedge clk);
        i_ifu_vld = ifu; i_ifu_pc = pc; i_ifu_id = id;
        i_pf_vld = pf; i_pf_pc = ppc; i_icache_stall = st; i_flush = fl;
        i_icache_rsp_vld = rv; i_icache_rsp_tag = rt;
        #1;
        nfree    = free_slots();
        first    = 0;
        while (first < 4 && m_busy[first]) first++;
        blocked  = st || fl || nfree == 0;
        overtake = m_wait >= 7 && pf && nfree > 1;
        eg_dem   = !blocked && ifu && !overtake;
        eg_pf    = !blocked && ((pf && !ifu && nfree > 1) || overtake);
        e_irsp   = rv && m_busy[rt] && !m_pf[rt] && !m_dead[rt] && !fl;
        e_prsp   = rv && m_busy[rt] && m_pf[rt];
        chk("ifu_rdy", o_ifu_rdy, eg_dem);
        chk("pf_rdy", o_pf_rdy, eg_pf);
        chk("icache_vld", o_icache_vld, eg_dem || eg_pf);
        if (eg_dem || eg_pf) begin
            chk("icache_pc", o_icache_pc, eg_pf ? ppc : pc);
            chk("icache_tag", o_icache_tag, first);
        end
        chk("ifu_rsp_vld", o_ifu_rsp_vld, e_irsp);
        if (e_irsp) chk("ifu_rsp_id", o_ifu_rsp_id, m_id[rt]);
        chk("pf_rsp_vld", o_pf_rsp_vld, e_prsp);
        s_ifu_rdy = o_ifu_rdy; s_pf_rdy = o_pf_rdy; s_icache_vld = o_icache_vld;
        s_tag = o_icache_tag; s_ifu_rsp_vld = o_ifu_rsp_vld; s_rsp_id = o_ifu_rsp_id;
        s_pf_rsp_vld = o_pf_rsp_vld;
        // advance the model to the state after this edge
        if (eg_dem) m_dem_cnt++;
        if (eg_pf) m_pf_cnt++;
        if (rv && m_busy[rt] && !m_pf[rt] && (m_dead[rt] || fl)) m_drop_cnt++;
        if (nfree == 0 && (ifu || pf)) m_full_cnt++;
        if (fl) for (int i = 0; i < 4; i++) if (m_busy[i] && !m_pf[i]) m_dead[i] = 1;
        if (rv) m_busy[rt] = 0;
        if (eg_dem || eg_pf) begin
            m_busy[first] = 1; m_pf[first] = eg_pf; m_dead[first] = 0; m_id[first] = id;
        end
        if (!st) begin
            if (!pf || eg_pf) m_wait = 0;
            else if (m_wait < 7) m_wait++;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic demand(input logic [31:0] pc, input logic [1:0] id);
        step(1, pc, id, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 8; k++) begin
            if (oldest_busy() >= 0) step(0, 0, 0, 0, 0, 0, 0, 1, 2'(oldest_busy()));
        end
        chk("drained", free_slots(), 4);
    endtask

    initial begin
        int t;
        bit rv;
        logic [1:0] rt;
        int cands [$];
        model_clear();
        // held in reset with a live request: nothing may be granted
        i_ifu_vld = 1; i_pf_vld = 1;
        repeat (2) @(negedge clk);
        chk("rst_ifu_rdy", o_ifu_rdy, 0);
        chk("rst_pf_rdy", o_pf_rdy, 0);
        chk("rst_icache_vld", o_icache_vld, 0);
        i_ifu_vld = 0; i_pf_vld = 0;
        rst_n = 1;

        // single demand round trip
        demand(32'h100, 2);
        chk("first_vld", s_icache_vld, 1);
        chk("first_tag", s_tag, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("first_rsp_vld", s_ifu_rsp_vld, 1);
        chk("first_rsp_id", s_rsp_id, 2);

        // demand beats prefetch until the prefetch has waited long enough
        for (int c = 0; c < 7; c++) begin
            t = oldest_busy();
            step(1, 32'h200 + c * 4, 1, 1, 32'h4000, 0, 0, t >= 0, 2'(t < 0 ? 0 : t));
            chk("age_dem_wins", s_ifu_rdy, 1);
        end
        t = oldest_busy();
        step(1, 32'h300, 1, 1, 32'h4000, 0, 0, t >= 0, 2'(t < 0 ? 0 : t));
        chk("age_pf_ovr", s_pf_rdy, 1);
        chk("age_dem_held", s_ifu_rdy, 0);
        step(1, 32'h304, 1, 1, 32'h4040, 0, 0, 0, 0);
        chk("age_cleared", s_ifu_rdy, 1);
        drain();

        // fill all four slots, then reuse the one that completes
        for (int c = 0; c < 4; c++) demand(32'h500 + c * 4, 2'(c));
        step(1, 32'h600, 0, 1, 32'h5000, 0, 0, 0, 0);
        chk("full_ifu_rdy", s_ifu_rdy, 0);
        chk("full_pf_rdy", s_pf_rdy, 0);
        step(1, 32'h600, 0, 0, 0, 0, 0, 1, 1);
        chk("free_same_cycle", s_ifu_rdy, 0);
        demand(32'h604, 0);
        chk("reuse_tag", s_tag, 1);
        drain();

        // flush kills outstanding demand lookups
        for (int c = 0; c < 3; c++) demand(32'h700 + c * 4, 2'(c));
        step(1, 32'h800, 0, 0, 0, 0, 1, 0, 0);
        chk("flush_no_grant", s_icache_vld, 0);
        for (int c = 0; c < 3; c++) begin
            step(0, 0, 0, 0, 0, 0, 0, 1, 2'(c));
            chk("killed_dropped", s_ifu_rsp_vld, 0);
        end
        demand(32'h900, 3);
        chk("post_flush_grant", s_ifu_rdy, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, s_tag);
        chk("post_flush_rsp", s_ifu_rsp_vld, 1);
        chk("post_flush_id", s_rsp_id, 3);

        // prefetch respects the demand reserve
        for (int c = 0; c < 3; c++) demand(32'hA00 + c * 4, 2'(c));
        step(0, 0, 0, 1, 32'h6000, 0, 0, 0, 0);
        chk("reserve_pf_blocked", s_pf_rdy, 0);
        demand(32'hA10, 3);
        chk("reserve_dem_ok", s_ifu_rdy, 1);
        drain();

        // stall freezes issue
        for (int c = 0; c < 5; c++) begin
            step(1, 32'hB00, 0, 1, 32'h7000, 1, 0, 0, 0);
            chk("stall_no_issue", s_icache_vld, 0);
        end
        step(1, 32'hB00, 0, 1, 32'h7000, 0, 0, 0, 0);
        drain();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            cands.delete();
            for (int i = 0; i < 4; i++) if (m_busy[i]) cands.push_back(i);
            rv = cands.size() > 0 && $urandom_range(99) < 45;
            rt = rv ? 2'(cands[$urandom_range(cands.size() - 1)]) : 2'd0;
            step($urandom_range(99) < 60, $urandom, 2'($urandom), $urandom_range(99) < 50, $urandom,
                 $urandom_range(4) == 0, $urandom_range(11) == 0, rv, rt);
        end
`ifdef ICACHE_FETCH_ARB_PERF_EN
        chk("perf_demand", o_perf_demand_issue, m_dem_cnt);
        chk("perf_pf", o_perf_pf_issue, m_pf_cnt);
        chk("perf_drop", o_perf_killed_drop, m_drop_cnt);
        chk("perf_full", o_perf_full_cycles, m_full_cnt);
`endif

        // reset mid-operation clears the scoreboard at once
        for (int c = 0; c < 2; c++) demand(32'hC00, 1);
        @(negedge clk);
        i_ifu_vld = 1; i_pf_vld = 1; i_icache_stall = 0; i_flush = 0;
        rst_n = 0;
        t = oldest_busy();
        i_icache_rsp_vld = t >= 0; i_icache_rsp_tag = 2'(t < 0 ? 0 : t);
        #1;
        chk("midrst_ifu_rdy", o_ifu_rdy, 0);
        chk("midrst_icache_vld", o_icache_vld, 0);
        chk("midrst_rsp", o_ifu_rsp_vld | o_pf_rsp_vld, 0);
        @(negedge clk);
        i_icache_rsp_vld = 0; i_ifu_vld = 0; i_pf_vld = 0;
        rst_n = 1;
        model_clear();
        demand(32'hD00, 2);
        chk("midrst_tag0", s_tag, 0);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/icache_fetch_arb.md
Name: icache_fetch_arb

Overview:
- Schedules the single icache lookup port between two requesters: the IFU demand fetch stream and the next-line prefetcher.
- Tracks up to 4 outstanding lookups in a tag scoreboard and routes each icache response back to its owner.
- Kills in-flight demand lookups on pipeline flush.
- Sits between the IFU/prefetcher and the icache front end.

Parameters:
- PC_WIDTH, 32, fetch address width (matches `CORE_PC_WIDTH).
- PF_AGE_MAX, 7, prefetch wait cycles before it overrides demand priority (3-bit counter).
- PF_RESERVE, 1, entries kept free for demand; prefetch is granted only when free count > PF_RESERVE.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_flush  in  1  any pipeline flush (trap/mispredict/ls/iq/bpu, already ORed).
- i_ifu_vld  in  1  demand fetch request.
- i_ifu_pc  in  PC_WIDTH  demand fetch address.
- i_ifu_id  in  2  IFU address-queue index, returned with the response.
- o_ifu_rdy  out  1  demand request accepted this cycle.
- i_pf_vld  in  1  prefetch request.
- i_pf_pc  in  PC_WIDTH  prefetch address.
- o_pf_rdy  out  1  prefetch request accepted this cycle.
- o_icache_vld  out  1  lookup issue.
- o_icache_pc  out  PC_WIDTH  lookup address.
- o_icache_tag  out  2  scoreboard entry index of the lookup.
- i_icache_stall  in  1  icache cannot accept a lookup.
- i_icache_rsp_vld  in  1  lookup complete.
- i_icache_rsp_tag  in  2  entry index of the completing lookup.
- o_ifu_rsp_vld  out  1  demand response to the IFU.
- o_ifu_rsp_id  out  2  stored i_ifu_id for that response.
- o_pf_rsp_vld  out  1  prefetch fill done.

Behaviour:
- Reset: scoreboard empty (all valid=0), free count 4, age counter 0. All o_*_vld and o_*_rdy are 0 while rst_n is low.
- Scoreboard entry contents: valid, owner (DEMAND/PREFETCH), killed, id[1:0]. Free count is 3 bits, range 0..4.
- Grant is combinational and is suppressed when i_icache_stall | i_flush | free==0. Outcomes:
  - DEMAND: i_ifu_vld and no age override.
  - PREFETCH: i_pf_vld & ~i_ifu_vld & free>PF_RESERVE, or age override.
  - Age override: age==PF_AGE_MAX & i_pf_vld & free>PF_RESERVE. Demand is not granted that cycle.
- Issue on grant:
  - o_icache_vld=1.
  - o_icache_pc = the selected pc.
  - o_icache_tag = lowest-index free entry.
  - The matching rdy is asserted.
  - The entry is written valid at the next edge. Latency from request to issue is 0 cycles.
- Age counter:
  - Increments while i_pf_vld & ~pf granted, saturating at PF_AGE_MAX.
  - Clears on pf grant or when i_pf_vld=0.
  - Holds while i_icache_stall=1.
- Response handling (i_icache_rsp_vld):
  - The entry is freed at the next edge.
  - DEMAND & ~killed: o_ifu_rsp_vld=1 with o_ifu_rsp_id=id, same cycle (combinational from the response).
  - PREFETCH: o_pf_rsp_vld=1.
  - DEMAND & killed: response dropped, no output.
  - Response to an invalid entry: ignored; assertion error in simulation.
- Flush:
  - All valid DEMAND entries get killed=1 at the next edge.
  - PREFETCH entries are untouched.
  - A demand response arriving in the flush cycle is dropped.
  - No grant in the flush cycle.
- Simultaneous response and grant: a freed entry is not reallocatable until the next cycle. The free count updates by +rsp −grant, so the net is 0 when both occur.
- Full: free==0 → both rdy=0, o_icache_vld=0, counter unchanged.
- Stall mid-operation: no issue; outstanding entries and responses proceed normally.
- Reset asserted mid-operation: the scoreboard clears immediately, and any responses arriving after reset release are ignored.

Optional Feature:
- ICACHE_FETCH_ARB_PERF_EN.
- Defined: adds the following, each 32-bit and wrapping:
  - o_perf_demand_issue: count of demand grants.
  - o_perf_pf_issue: count of prefetch grants.
  - o_perf_killed_drop: count of dropped demand responses.
  - o_perf_full_cycles: count of cycles with free==0 & (i_ifu_vld|i_pf_vld).
  - All reset to 0.
- Undefined: these ports and counters are absent. Arbitration is unchanged.

Decomposition:
- Shared package/header holds:
  - ICACHE_TAG_WIDTH=2 and ICACHE_ARB_ENTRIES=4.
  - Owner encoding: DEMAND=1'b0, PREFETCH=1'b1.
  - Lowest-free-index priority function.
- One sub-module, icache_fetch_arb_sb: the 4-entry scoreboard (alloc, free, kill, lookup, free count). Grant logic and the age counter stay in the top module.

Test Plan:
- Reset then i_ifu_vld=1, pc=0x100, id=2 → o_icache_vld=1, tag=0, rdy=1. Rsp tag=0 two cycles later → o_ifu_rsp_vld=1, id=2.
- Demand and prefetch valid together with 4 free entries → demand granted. pf held 7 cycles with demand continuous → 8th cycle pf granted, age cleared.
- Issue 4 demands, no responses → free=0, both rdy=0. A response to tag=1 → the next grant uses tag=1.
- 3 demands outstanding, i_flush pulse, then responses for tags 0–2 → no o_ifu_rsp_vld. A new demand after the flush gets a free tag and its response is delivered.
- free==1 with only i_pf_vld → no pf grant (reserve). Demand → granted.
- i_icache_stall=1 for 5 cycles with both valid → no issue, age frozen. With PERF_EN, counters match the grant/drop totals.
